alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: ALU_LATENCY, default 1, cycles from the alu_enable cycle to a valid alu_result (legal 0..7).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high; ports SHALL be named clock and reset.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid  in  2  per-requester operation request; bit i = requester i.
REQ-006 req_ready  out  2  per-requester accept; one-hot or zero.
REQ-007 req_funct3  in  6  requester i at [3i+2:3i].
REQ-008 req_funct7  in  14  requester i at [7i+6:7i].
REQ-009 req_rs1  in  64  operand 1; requester i at [32i+31:32i].
REQ-010 req_rs2  in  64  operand 2; same packing as req_rs1.
REQ-011 rsp_valid  out  2  result available for requester i; one-hot or zero.
REQ-012 rsp_ready  in  2  requester i consumes the result.
REQ-013 rsp_data  out  32  result for the requester whose rsp_valid bit is set.
REQ-014 alu_enable  out  1  ALU enable; high for exactly one cycle per operation.
REQ-015 alu_funct3 / alu_funct7 / alu_rs1 / alu_rs2  out  3/7/32/32  latched operation to the ALU.
REQ-016 alu_result  in  32  ALU output.
REQ-017 busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE: req_ready SHALL be set one-hot to the winner whenever any req_valid bit is high; a transfer is req_valid[i] & req_ready[i] on the same edge; on transfer: latch funct3/funct7/rs1/rs2, record owner=i, go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: both valid -> grant the priority-pointer requester; one valid -> grant it; after a grant the pointer SHALL move to the other requester.
REQ-021 ISSUE: alu_enable=1 for one cycle; load the counter with ALU_LATENCY; with ALU_LATENCY=0, capture alu_result at this edge and go to RESP; otherwise go to WAIT.
REQ-022 WAIT: alu_enable=0; decrement the counter each cycle; capture alu_result and go to RESP on the edge at the end of cycle ISSUE+ALU_LATENCY.
REQ-023 alu_funct3/funct7/rs1/rs2 SHALL hold the latched values from ISSUE through RESP.
REQ-024 RESP: rsp_valid[owner]=1 and rsp_data=captured result, both stable until rsp_ready[owner]; on that handshake go to IDLE; rsp_ready of the non-owner SHALL be ignored.
REQ-025 Latency: transfer at edge ending cycle T -> rsp_valid in cycle T+2+ALU_LATENCY.
REQ-026 req_ready SHALL be 0 in every state except IDLE; a request deasserted before it is accepted has no effect.
REQ-027 The captured result register SHALL change only on the capture edge.

Reset
REQ-028 On reset: state=IDLE, pointer=requester 0, and all outputs 0 (req_ready, rsp_valid, rsp_data, alu_enable, alu_funct3/7, alu_rs1/2, busy).
REQ-029 Reset in any state SHALL abandon the in-flight operation with no response.

Structure
REQ-030 A shared package alu_arb_pkg SHALL hold the state enum, the funct3 ADD/SUB code 3'b000, the funct7 codes (7'h00 base, 7'h20 SUB) and the maximum-latency constant.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter_2 (inputs: valid[1:0], pointer; output: one-hot grant).

Verification
REQ-032 ALU_LATENCY=1, requester 0 sends funct3=0, funct7=0, rs1=1, rs2=2 -> alu_enable for one cycle with those values; rsp_valid[0] at T+3; rsp_data=3.
REQ-033 Right after reset, both requesters valid in the same cycle (req0: ADD 1,2; req1: funct7=0x20, 5,3) -> req0 is granted first, rsp 3; req_ready[1] stays 0 until the req0 response handshake; then req1 is granted, rsp 2.
REQ-034 Both requesters continuously valid for 4 operations -> grants alternate 0,1,0,1.
REQ-035 rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_data stable; req_ready=0 and alu_enable=0 throughout.
REQ-036 ALU_LATENCY=3, reset asserted during WAIT -> the next cycle has all outputs 0 and no rsp_valid; a subsequent request from requester 1 alone is granted.
REQ-037 ALU_LATENCY=0 -> rsp_valid at T+2 with the correct sum.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state enum, ALU function codes and latency limits for the ALU arbiter
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB = 7'h20;
  localparam int MAX_LATENCY = 7;
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant, the pointer requester wins when both are valid
module rr_arbiter_2
  import alu_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);
  assign grant = &valid ? onehot2(pointer) : valid;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one fixed-latency ALU between two requesters with round-robin arbitration
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_funct3,
  input  logic [13:0] req_funct7,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        alu_enable,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  input  logic [31:0] alu_result,
  output logic        busy
);
  state_e state_q, state_d;
  logic ptr_q, ptr_d;
  logic owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] funct3_q, funct3_d;
  logic [6:0] funct7_q, funct7_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] result_q, result_d;
  logic [1:0] grant;

  rr_arbiter_2 u_rr (
    .valid  (req_valid),
    .pointer(ptr_q),
    .grant  (grant)
  );

  // next state: accept a request in IDLE, pulse the ALU, count down its latency, hold the response
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    funct3_d = funct3_q;
    funct7_d = funct7_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    result_d = result_q;
    req_ready = 2'b00;
    alu_enable = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = reset ? 2'b00 : grant;
        if (|req_ready) begin
          owner_d = req_ready[1];
          ptr_d = ~req_ready[1];
          funct3_d = req_ready[1] ? req_funct3[5:3] : req_funct3[2:0];
          funct7_d = req_ready[1] ? req_funct7[13:7] : req_funct7[6:0];
          rs1_d = req_ready[1] ? req_rs1[63:32] : req_rs1[31:0];
          rs2_d = req_ready[1] ? req_rs2[63:32] : req_rs2[31:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_enable = 1'b1;
        cnt_d = CNT_W'(ALU_LATENCY);
        if (ALU_LATENCY == 0) begin
          result_d = alu_result;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = alu_result;
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_ready[owner_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared by synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      owner_q <= 1'b0;
      cnt_q <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      result_q <= result_d;
    end
  end

  assign alu_funct3 = funct3_q;
  assign alu_funct7 = funct7_q;
  assign alu_rs1 = rs1_q;
  assign alu_rs2 = rs2_q;
  assign rsp_data = result_q;
  assign rsp_valid = (state_q == RESP) ? onehot2(owner_q) : 2'b00;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: three arbiters (latency 1, 0, 3) checked against a cycle-timeline model
module tb_alu_arbiter;
  logic clock = 0;
  always #5 clock = ~clock;

  logic [1:0] req_valid[3], req_ready[3], rsp_valid[3], rsp_ready[3];
  logic [5:0] req_funct3[3];
  logic [13:0] req_funct7[3];
  logic [63:0] req_rs1[3], req_rs2[3];
  logic [31:0] rsp_data[3], alu_rs1[3], alu_rs2[3];
  logic [2:0] alu_funct3[3];
  logic [6:0] alu_funct7[3];
  logic alu_enable[3], busy[3], reset[3];
  int cyc = 0, total = 0, pass_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string nm, logic [79:0] act, logic [79:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] alu_fn(logic [2:0] f3, logic [6:0] f7, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return f7 == 7'h20 ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'b0, $signed(a) < $signed(b)};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7 == 7'h20 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [1:0] pick(logic [1:0] v, logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    logic [31:0] alu_res = 0;
    int iss = -100;
    logic armed = 0, free = 1, ptr = 0, owner = 0, ops_ok = 0, resp = 0;
    int t_acc = 0, o = 0;
    logic [73:0] ops = '0;
    logic [31:0] res = 0, last = 0;
    logic [1:0] gnt = 0;

    alu_arbiter #(.ALU_LATENCY(L)) dut (
      .clock(clock), .reset(reset[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_funct3(req_funct3[g]), .req_funct7(req_funct7[g]), .req_rs1(req_rs1[g]), .req_rs2(req_rs2[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
      .alu_enable(alu_enable[g]), .alu_funct3(alu_funct3[g]), .alu_funct7(alu_funct7[g]),
      .alu_rs1(alu_rs1[g]), .alu_rs2(alu_rs2[g]), .alu_result(alu_res), .busy(busy[g])
    );

    // external ALU: correct result only in the cycle L after enable, inverted junk otherwise
    always @(negedge clock) begin
      if (alu_enable[g]) iss = cyc;
      alu_res = (cyc == iss + L) ? alu_fn(alu_funct3[g], alu_funct7[g], alu_rs1[g], alu_rs2[g])
                                 : ~alu_fn(alu_funct3[g], alu_funct7[g], alu_rs1[g], alu_rs2[g]);
    end

    always @(negedge clock) begin
      if (reset[g]) begin
        armed = 1; free = 1; ptr = 0; last = 0; ops = '0; ops_ok = 1;
      end else if (armed) begin
        resp = !free && cyc >= t_acc + 2 + L;
        gnt = free ? pick(req_valid[g], ptr) : 2'b00;
        check($sformatf("m%0d req_ready", g), req_ready[g], gnt);
        check($sformatf("m%0d alu_enable", g), alu_enable[g], !free && cyc == t_acc + 1);
        check($sformatf("m%0d rsp_valid", g), rsp_valid[g], resp ? (2'b01 << owner) : 2'b00);
        check($sformatf("m%0d rsp_data", g), rsp_data[g], resp ? res : last);
        check($sformatf("m%0d busy", g), busy[g], !free);
        if (ops_ok)
          check($sformatf("m%0d alu_ops", g), {alu_funct3[g], alu_funct7[g], alu_rs1[g], alu_rs2[g]}, ops);
        if (gnt != 2'b00) begin
          owner = gnt[1]; o = int'(gnt[1]); ptr = !gnt[1]; t_acc = cyc; free = 0; ops_ok = 1;
          ops = {req_funct3[g][3*o +: 3], req_funct7[g][7*o +: 7], req_rs1[g][32*o +: 32], req_rs2[g][32*o +: 32]};
          res = alu_fn(ops[73:71], ops[70:64], ops[63:32], ops[31:0]);
        end else if (resp && rsp_ready[g][owner]) begin
          free = 1; last = res; ops_ok = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(int i, int r, logic [2:0] f3, logic [6:0] f7, logic [31:0] a, logic [31:0] b);
    req_funct3[i][3*r +: 3] = f3;
    req_funct7[i][7*r +: 7] = f7;
    req_rs1[i][32*r +: 32] = a;
    req_rs2[i][32*r +: 32] = b;
    req_valid[i][r] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic g4[4];
    logic [6:0] f7r;
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1; req_valid[i] = 0; rsp_ready[i] = 0;
      req_funct3[i] = 0; req_funct7[i] = 0; req_rs1[i] = 0; req_rs2[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) reset[i] = 0;
    @(negedge clock);
    check("reset outputs", {req_ready[0], rsp_valid[0], rsp_data[0], alu_enable[0], busy[0]}, 0);
    tick();
    // latency 1: both requesters valid right after reset
    set_req(0, 0, 3'd0, 7'h00, 1, 2);
    set_req(0, 1, 3'd0, 7'h20, 5, 3);
    rsp_ready[0] = 2'b10;
    @(negedge clock); check("d1 grant req0", req_ready[0], 2'b01);
    tick(); @(negedge clock);
    check("d1 issue enable", alu_enable[0], 1);
    check("d1 issue ops", {alu_funct3[0], alu_funct7[0], alu_rs1[0], alu_rs2[0]}, {3'd0, 7'd0, 32'd1, 32'd2});
    tick(); @(negedge clock);
    check("d1 wait quiet", {alu_enable[0], rsp_valid[0], req_ready[0]}, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("d1 resp hold", {rsp_valid[0], rsp_data[0], req_ready[0], alu_enable[0]}, {2'b01, 32'd3, 2'b00, 1'b0});
      tick();
    end
    rsp_ready[0] = 2'b01;
    @(negedge clock); check("d1 resp last", rsp_valid[0], 2'b01);
    tick(); rsp_ready[0] = 2'b11;
    @(negedge clock); check("d2 grant req1", req_ready[0], 2'b10);
    repeat (3) tick();
    @(negedge clock); check("d2 resp", {rsp_valid[0], rsp_data[0]}, {2'b10, 32'd2});
    tick();
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clock);
      if (req_ready[0] != 2'b00) begin g4[n] = req_ready[0][1]; n++; end
      tick();
    end
    check("d3 grant count", n, 4);
    check("d3 grant order", {g4[0], g4[1], g4[2], g4[3]}, 4'b0101);
    req_valid[0] = 0;
    repeat (8) tick();
    rsp_ready[0] = 0;
    // latency 0
    set_req(1, 0, 3'd0, 7'h00, 10, 20);
    rsp_ready[1] = 2'b01;
    @(negedge clock); check("d4 grant", req_ready[1], 2'b01);
    tick(); req_valid[1] = 0;
    @(negedge clock); check("d4 issue", {alu_enable[1], rsp_valid[1]}, {1'b1, 2'b00});
    tick(); @(negedge clock);
    check("d4 resp", {rsp_valid[1], rsp_data[1]}, {2'b01, 32'd30});
    tick(); @(negedge clock); check("d4 done", rsp_valid[1], 2'b00);
    rsp_ready[1] = 0;
    // latency 3: reset during WAIT
    set_req(2, 0, 3'd0, 7'h20, 9, 4);
    tick(); req_valid[2] = 0;
    tick(); tick();
    reset[2] = 1;
    tick(); reset[2] = 0;
    @(negedge clock);
    check("d5 after reset", {req_ready[2], rsp_valid[2], rsp_data[2], alu_enable[2], alu_funct3[2],
                             alu_funct7[2], alu_rs1[2], busy[2]}, 0);
    check("d5 after reset rs2", alu_rs2[2], 0);
    for (int k = 0; k < 6; k++) begin
      tick(); @(negedge clock); check("d5 no resp", rsp_valid[2], 2'b00);
    end
    tick();
    set_req(2, 1, 3'd0, 7'h00, 7, 8);
    rsp_ready[2] = 2'b10;
    @(negedge clock); check("d6 grant req1", req_ready[2], 2'b10);
    tick(); req_valid[2] = 0;
    repeat (4) tick();
    @(negedge clock); check("d6 resp", {rsp_valid[2], rsp_data[2]}, {2'b10, 32'd15});
    tick(); rsp_ready[2] = 0;
    // randomized traffic on each instance
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 400; c++) begin
        for (int r = 0; r < 2; r++) begin
          f7r = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          if ($urandom_range(0, 7) == 0) f7r = 7'($urandom);
          set_req(i, r, 3'($urandom), f7r, $urandom, $urandom);
          req_valid[i][r] = $urandom_range(0, 3) != 0;
        end
        rsp_ready[i] = 2'($urandom);
        reset[i] = $urandom_range(0, 99) == 0;
        tick();
      end
      reset[i] = 0; req_valid[i] = 0; rsp_ready[i] = 2'b11;
      repeat (10) tick();
      rsp_ready[i] = 0;
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
